// File: rtl/ama_riscv_perf_cnt_if.sv
// MMIO read port of ama_riscv_perf_cnt: strobe + word index in,
// registered data + valid qualifier out one cycle later.
interface ama_riscv_perf_cnt_if;
  logic        rd_req;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_data,
    output rd_valid
  );
endinterface

// File: rtl/ama_riscv_perf_cnt.sv
// Core performance counters (cycle, instret, optional stall) with a 32-bit MMIO read port.
// Define AMA_RISCV_PERF_STALL_CNT_EN to build the stall counter at words 4-5.
module ama_riscv_perf_cnt #(
  parameter int CNT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inst_wb_nop_or_clear,
  input  logic                 bubble_dec,
  input  logic                 mmio_reset_cnt,
  ama_riscv_perf_cnt_if.slave  rd_if
);

`ifdef AMA_RISCV_PERF_STALL_CNT_EN
  localparam int N_CNT = 3;
`else
  localparam int N_CNT = 2;
  logic unused_bubble_dec;
  assign unused_bubble_dec = bubble_dec;
`endif
  localparam int HI_W = CNT_W - 32;

  // Read-mux views indexed by rd_addr[2:1]; slots without a counter read as 0.
  logic [31:0] cnt_lo [4];
  logic [31:0] cnt_hi [4];

  logic [31:0] rd_data_q;
  logic [31:0] rd_data_d;
  logic        rd_valid_q;
  logic        rd_valid_d;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      if (gi < N_CNT) begin : g_live
        logic             inc;
        logic             lo_rd;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [HI_W-1:0]  shadow_q;
        logic [HI_W-1:0]  shadow_d;

        if (gi == 0) begin : g_inc_cycle
          assign inc = 1'b1;
        end else if (gi == 1) begin : g_inc_instret
          assign inc = ~inst_wb_nop_or_clear;
        end else begin : g_inc_stall
          assign inc = bubble_dec;
        end

        assign lo_rd = rd_if.rd_req && (rd_if.rd_addr == {2'(gi), 1'b0});

        // Clear beats increment; the shadow is untouched by the clear.
        always_comb begin
          cnt_d    = cnt_q + CNT_W'(inc);
          shadow_d = shadow_q;
          if (mmio_reset_cnt) begin
            cnt_d = '0;
          end
          if (lo_rd) begin
            shadow_d = cnt_q[CNT_W-1:32];
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
          end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
          end
        end

        assign cnt_lo[gi] = cnt_q[31:0];
        assign cnt_hi[gi] = 32'(shadow_q);
      end else begin : g_none
        assign cnt_lo[gi] = 32'h0;
        assign cnt_hi[gi] = 32'h0;
      end
    end
  endgenerate

  // Values are taken from the pre-edge counters, so a read that coincides
  // with a clear still returns the old count.
  always_comb begin
    rd_valid_d = rd_if.rd_req;
    rd_data_d  = 32'h0;
    if (rd_if.rd_req) begin
      rd_data_d = rd_if.rd_addr[0] ? cnt_hi[rd_if.rd_addr[2:1]]
                                   : cnt_lo[rd_if.rd_addr[2:1]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= 32'h0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_if.rd_data  = rd_data_q;
  assign rd_if.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ama_riscv_perf_cnt.sv
// Self-checking bench for ama_riscv_perf_cnt: vector table, directed corner
// sequences and a randomized run against a counter/shadow reference model.
module tb_ama_riscv_perf_cnt;
  localparam int CNT_W = 64;
`ifdef AMA_RISCV_PERF_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic nop;
  logic bub;
  logic clr;

  ama_riscv_perf_cnt_if rd_if ();

  ama_riscv_perf_cnt #(.CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .inst_wb_nop_or_clear (nop),
    .bubble_dec           (bub),
    .mmio_reset_cnt       (clr),
    .rd_if                (rd_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counter k lives at words 2k (lo) / 2k+1 (hi shadow).
  logic [CNT_W-1:0] m_cnt    [3];
  logic [31:0]      m_shadow [3];
  logic             exp_valid;
  logic [31:0]      exp_data;

  typedef struct {
    logic        nop;
    logic        bub;
    logic        clr;
    logic        req;
    logic [2:0]  addr;
    logic        vld;
    logic [31:0] data;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic chk_rd(input string name, input logic v, input logic [31:0] d);
    check({name, " rd_valid"}, 32'(rd_if.rd_valid), 32'(v));
    check({name, " rd_data"}, rd_if.rd_data, d);
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    int k;
    k = int'(a[2:1]);
    if (k == 3 || (k == 2 && !STALL_EN)) return 32'h0;
    if (a[0]) return m_shadow[k];
    m_shadow[k] = 32'(m_cnt[k] >> 32);
    return m_cnt[k][31:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k]    = '0;
      m_shadow[k] = '0;
    end
  endtask

  // One clock: drive inputs, predict the read result, advance, sample at +1.
  task automatic step(input logic n, input logic b, input logic c, input logic r, input logic [2:0] a);
    nop = n;
    bub = b;
    clr = c;
    rd_if.rd_req  = r;
    rd_if.rd_addr = a;
    exp_valid = r;
    if (r) exp_data = model_read(a);
    else   exp_data = 32'h0;
    @(posedge clk);
    #1;
    if (c) begin
      for (int k = 0; k < 3; k++) m_cnt[k] = '0;
    end else begin
      m_cnt[0] += 1;
      m_cnt[1] += CNT_W'(!n);
      m_cnt[2] += CNT_W'(b);
    end
    if (r) $display("rd addr=%0d -> valid=%0b data=0x%08h", a, rd_if.rd_valid, rd_if.rd_data);
  endtask

  task automatic poke_cycle(input logic [CNT_W-1:0] v);
    dut.g_cnt[0].g_live.cnt_q = v;
    m_cnt[0] = v;
  endtask

  task automatic poke_instret(input logic [CNT_W-1:0] v);
    dut.g_cnt[1].g_live.cnt_q = v;
    m_cnt[1] = v;
  endtask

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    nop = 1'b1;
    bub = 1'b0;
    clr = 1'b0;
    rd_if.rd_req  = 1'b0;
    rd_if.rd_addr = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_rd("reset", 1'b0, 32'h0);
    rst_n = 1'b1;

    // 10 cycles alternating retire, then the read-port table
    for (int i = 0; i < 10; i++)
      tbl.push_back('{1'(i % 2), 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 32'd10});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 32'd5});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 32'd5});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 32'd6});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 32'h0});
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].nop, tbl[i].bub, tbl[i].clr, tbl[i].req, tbl[i].addr);
      chk_rd($sformatf("vec%0d", i), tbl[i].vld, tbl[i].data);
    end

    // lo/hi split across a 32-bit carry: hi comes from the shadow
    poke_cycle(64'h0000_0000_FFFF_FFFF);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);  chk_rd("split lo", 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd1);  chk_rd("split hi", 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);  chk_rd("live lo", 1'b1, 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd1);  chk_rd("live hi", 1'b1, 32'h1);

    // clear concurrent with a read; shadows survive the clear
    poke_cycle(64'h0000_0005_0000_0003);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);  chk_rd("pre-clr lo", 1'b1, 32'h3);
    poke_instret(64'd42);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd2);  chk_rd("clr+read", 1'b1, 32'd42);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);  chk_rd("clr idle", 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd2);  chk_rd("post-clr instret", 1'b1, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd1);  chk_rd("shadow kept", 1'b1, 32'h5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);  chk_rd("post-clr cycle", 1'b1, 32'd3);

    // full-width wrap of cycle
    poke_cycle('1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);  chk_rd("wrap edge", 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);  chk_rd("wrap lo", 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd1);  chk_rd("wrap hi", 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd2);  chk_rd("wrap instret", 1'b1, 32'd1);

    // stall counter: 7 bubbles after a clear
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    repeat (7) step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd4);  chk_rd("stall lo", 1'b1, STALL_EN ? 32'd7 : 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd5);  chk_rd("stall hi", 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd6);  chk_rd("unmapped 6", 1'b1, 32'h0);

    // asynchronous reset in the middle of a read
    poke_cycle(64'h0000_0007_0000_0000);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);  chk_rd("pre-rst lo", 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd1);  chk_rd("pre-rst hi", 1'b1, 32'h7);
    rd_if.rd_req  = 1'b1;
    rd_if.rd_addr = 3'd1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_rd("async rst", 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk_rd("in rst", 1'b0, 32'h0);
    rst_n = 1'b1;
    rd_if.rd_req = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);  chk_rd("no pulse", 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd1);  chk_rd("rst shadow", 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0);  chk_rd("rst cycle", 1'b1, 32'd2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd2);  chk_rd("rst instret", 1'b1, 32'd0);

    // randomized traffic against the model, starting near carry/wrap points
    poke_cycle(64'h0000_0000_FFFF_FFF0);
    poke_instret(64'hFFFF_FFFF_FFFF_FFF8);
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 2) != 0),
           3'($urandom_range(0, 7)));
      chk_rd($sformatf("rnd%0d", i), exp_valid, exp_data);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ama_riscv_perf_cnt.md
AMA_RISCV_PERF_CNT -- requirements
Module: ama_riscv_perf_cnt

Interface
REQ-001 SHALL have parameter CNT_W, default 64, counter width in bits; legal range 33..64.
REQ-002 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port inst_wb_nop_or_clear  input  1  1 = writeback slot holds no retiring instruction this cycle.
REQ-005 SHALL have port bubble_dec  input  1  1 = fetch/decode stalled this cycle.
REQ-006 SHALL have port mmio_reset_cnt  input  1  single-cycle request to clear all counters.
REQ-007 SHALL have port rd_req  input  1  MMIO read strobe, one read per asserted cycle.
REQ-008 SHALL have port rd_addr  input  3  word index: 0 cycle_lo, 1 cycle_hi, 2 instret_lo, 3 instret_hi, 4 stall_lo, 5 stall_hi, 6-7 unmapped.
REQ-009 SHALL have port rd_data  output  32  read data.
REQ-010 SHALL have port rd_valid  output  1  rd_data valid qualifier.

Function
REQ-011 SHALL keep three CNT_W-bit counters: cycle, instret, stall.
- cycle: +1 every clock after reset release.
- instret: +1 when inst_wb_nop_or_clear=0.
- stall: +1 when bubble_dec=1.
REQ-012 SHALL wrap each counter modulo 2^CNT_W with no saturation and no flag.
REQ-013 SHALL clear all counters to 0 on the edge where mmio_reset_cnt=1; clear wins over any increment in the same cycle, and counting resumes on the next edge.
REQ-014 SHALL register reads with fixed one-cycle latency: rd_req at edge N gives rd_valid=1 and rd_data during cycle N+1 only.
REQ-015 SHALL return counter values sampled before the edge-N update, including when mmio_reset_cnt=1 in the same cycle.
REQ-016 SHALL, on a read of any *_lo word, return bits [31:0] and copy bits [CNT_W-1:32] into that counter's hi shadow register.
REQ-017 SHALL return the hi shadow, zero-extended to 32 bits, on a *_hi read; the live counter SHALL NOT be read. This gives a tear-free 64-bit read with lo then hi.
REQ-018 SHALL NOT clear hi shadows on mmio_reset_cnt; shadows change only via lo reads or rst_n.
REQ-019 SHALL return rd_data=0 with rd_valid=1 for unmapped addresses.
REQ-020 SHALL drive rd_valid=0 and rd_data=0 in every cycle not preceded by rd_req.
REQ-021 SHALL accept back-to-back rd_req every cycle with no bubbles.

Reset
REQ-022 SHALL, while rst_n=0 (asynchronously), force counters, hi shadows, rd_data=0 and rd_valid=0.
REQ-023 SHALL treat rst_n assertion mid-read as aborting the read: no rd_valid pulse follows.
REQ-024 SHALL make the first rising edge with rst_n=1 the first counted edge, leaving cycle=1 after it.

Configuration
REQ-025 SHALL compile the stall counter and its shadow only when AMA_RISCV_PERF_STALL_CNT_EN is defined.
REQ-026 SHALL, without AMA_RISCV_PERF_STALL_CNT_EN, leave bubble_dec unused and treat addresses 4-5 as unmapped (return 0).

Verification
REQ-027 SHALL cover: release reset, run 10 cycles with inst_wb_nop_or_clear alternating 0/1 starting at 0, then read addr 0 and addr 2 -> rd_data 10 and 5, each rd_valid one cycle after its rd_req.
REQ-028 SHALL cover: force cycle to 0x0000_0000_FFFF_FFFF, read addr 0 at that edge, read addr 1 on the next edge -> 0xFFFF_FFFF then 0x0000_0000 (shadow, not the live 0x1).
REQ-029 SHALL cover: assert mmio_reset_cnt and rd_req addr 2 together with instret=42 -> rd_data 42, and instret=0 or 1 on the following read depending on retire.
REQ-030 SHALL cover: force cycle to 2^CNT_W-1 and advance one clock -> cycle reads 0 with no other side effect.
REQ-031 SHALL cover: rd_req on addr 6 and on addr 4 with AMA_RISCV_PERF_STALL_CNT_EN undefined -> rd_data 0, rd_valid 1; with the macro defined and bubble_dec held 1 for 7 cycles -> addr 4 reads 7.
REQ-032 SHALL cover: drop rst_n mid-cycle while rd_req=1 -> rd_valid and rd_data are 0 immediately and no rd_valid pulse occurs after release.
